// File: rtl/simd_sequencer.sv
// Run-control for the SIMD core: streams a host program into instruction memory,
// then sequences decoder reset, half-clock phase and stall, and keeps run counters.
module simd_sequencer #(
  parameter int INS_ADDR_WIDTH = 10,
  parameter int INS_WIDTH      = 33,
  parameter int DRAIN_CYCLES   = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [INS_WIDTH-1:0]      ld_data,
  input  logic                      ld_last,
  output logic                      ins_we,
  output logic [INS_ADDR_WIDTH-1:0] ins_waddr,
  output logic [INS_WIDTH-1:0]      ins_wdata,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      ext_stall,
  output logic                      busy,
  output logic                      done,
  output logic [INS_ADDR_WIDTH:0]   prog_len,
  output logic                      dec_rstn,
  output logic                      half_clk,
  output logic                      stall,
  input  logic                      ins_done,
  output logic [CNT_WIDTH-1:0]      run_cycles,
  output logic [CNT_WIDTH-1:0]      ins_issued
);
  localparam int PW = INS_ADDR_WIDTH + 1;
  localparam int DW = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                    r_state;
  logic                      r_ins_we;
  logic [INS_ADDR_WIDTH-1:0] r_ins_waddr;
  logic [INS_WIDTH-1:0]      r_ins_wdata;
  logic [PW-1:0]             r_prog_len;
  logic                      r_closed;
  logic                      r_dec_rstn;
  logic                      r_half_clk;
  logic                      r_stall;
  logic                      r_busy;
  logic                      r_done;
  logic [CNT_WIDTH-1:0]      r_run_cycles;
  logic [CNT_WIDTH-1:0]      r_ins_issued;
  logic [DW-1:0]             r_drain;

  logic                      w_accept;
  logic                      w_retire;
  logic                      w_last;
  logic                      w_abort;
  logic [INS_ADDR_WIDTH-1:0] w_waddr;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // A closed program means the next accepted word restarts at address 0, so
  // a full-but-closed memory can still take a fresh program.
  assign ld_ready = (r_state == S_IDLE) & ~start & (r_closed | ~r_prog_len[INS_ADDR_WIDTH]);
  assign w_accept = ld_valid & ld_ready;
  assign w_waddr  = r_closed ? '0 : r_prog_len[INS_ADDR_WIDTH-1:0];
  assign w_retire = (r_state == S_RUN) & r_half_clk & ~ext_stall;
  assign w_last   = ins_done | ((r_ins_issued + CNT_WIDTH'(1)) == CNT_WIDTH'(r_prog_len));
  assign w_abort  = abort & ((r_state == S_CLR) | (r_state == S_RUN) | (r_state == S_DRAIN));

  assign ins_we     = r_ins_we;
  assign ins_waddr  = r_ins_waddr;
  assign ins_wdata  = r_ins_wdata;
  assign prog_len   = r_prog_len;
  assign dec_rstn   = r_dec_rstn;
  assign half_clk   = r_half_clk;
  assign stall      = r_stall | ((r_state == S_RUN) & ext_stall);
  assign busy       = r_busy;
  assign done       = r_done;
  assign run_cycles = r_run_cycles;
  assign ins_issued = r_ins_issued;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_ins_we     <= 1'b0;
      r_ins_waddr  <= '0;
      r_ins_wdata  <= '0;
      r_prog_len   <= '0;
      r_closed     <= 1'b0;
      r_dec_rstn   <= 1'b0;
      r_half_clk   <= 1'b0;
      r_stall      <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_run_cycles <= '0;
      r_ins_issued <= '0;
      r_drain      <= '0;
    end else begin
      r_ins_we <= w_accept;
      r_done   <= 1'b0;
      if (w_accept) begin
        r_ins_waddr <= w_waddr;
        r_ins_wdata <= ld_data;
        r_prog_len  <= r_closed ? PW'(1) : r_prog_len + PW'(1);
        r_closed    <= ld_last;
      end
      if (w_abort) begin
        r_state    <= S_IDLE;
        r_busy     <= 1'b0;
        r_half_clk <= 1'b0;
        r_stall    <= 1'b1;
        r_dec_rstn <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_busy <= 1'b1;
              if (r_prog_len != '0) begin
                r_state <= S_CLR;
              end else begin
                r_state      <= S_DONE;
                r_done       <= 1'b1;
                r_run_cycles <= '0;
                r_ins_issued <= '0;
              end
            end
          end
          S_CLR: begin
            r_run_cycles <= '0;
            r_ins_issued <= '0;
            r_half_clk   <= 1'b0;
            r_dec_rstn   <= 1'b1;
            r_stall      <= 1'b0;
            r_state      <= S_RUN;
          end
          S_RUN: begin
            r_run_cycles <= sat_inc(r_run_cycles);
            if (!ext_stall) r_half_clk <= ~r_half_clk;
            if (w_retire) begin
              r_ins_issued <= sat_inc(r_ins_issued);
              if (w_last) begin
                r_state    <= S_DRAIN;
                r_half_clk <= 1'b0;
                r_stall    <= 1'b1;
                r_drain    <= '0;
              end
            end
          end
          S_DRAIN: begin
            r_run_cycles <= sat_inc(r_run_cycles);
            if (r_drain == DRAIN_LAST) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_dec_rstn <= 1'b0;
            end else begin
              r_drain <= r_drain + DW'(1);
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_simd_sequencer.sv
// Directed + randomized bench for simd_sequencer; expected run traces come from a
// per-run model of phase/retire arithmetic over a pre-drawn stall pattern.
module tb_simd_sequencer;
  localparam int AW = 10;
  localparam int IW = 33;
  localparam int DC = 2;
  localparam int CW = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn, ld_valid, ld_ready, ld_last, ins_we;
  logic [IW-1:0] ld_data, ins_wdata;
  logic [AW-1:0] ins_waddr;
  logic          start, abort, ext_stall, busy, done;
  logic [AW:0]   prog_len;
  logic          dec_rstn, half_clk, stall, ins_done;
  logic [CW-1:0] run_cycles, ins_issued;

  int n_tests = 0;
  int n_fail  = 0;
  int m_len   = 0;
  bit m_closed = 1'b0;

  always #5 clk = ~clk;

  simd_sequencer #(
    .INS_ADDR_WIDTH(AW), .INS_WIDTH(IW), .DRAIN_CYCLES(DC), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_last(ld_last), .ins_we(ins_we), .ins_waddr(ins_waddr), .ins_wdata(ins_wdata),
    .start(start), .abort(abort), .ext_stall(ext_stall), .busy(busy), .done(done),
    .prog_len(prog_len), .dec_rstn(dec_rstn), .half_clk(half_clk), .stall(stall),
    .ins_done(ins_done), .run_cycles(run_cycles), .ins_issued(ins_issued)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; start = 1'b0;
    abort = 1'b0; ext_stall = 1'b0; ins_done = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " ins_we"}, ins_we, 0);
    chk({tag, " ins_waddr"}, ins_waddr, 0);
    chk({tag, " ins_wdata"}, ins_wdata, 0);
    chk({tag, " prog_len"}, prog_len, 0);
    chk({tag, " dec_rstn"}, dec_rstn, 0);
    chk({tag, " half_clk"}, half_clk, 0);
    chk({tag, " stall"}, stall, 1);
    chk({tag, " run_cycles"}, run_cycles, 0);
    chk({tag, " ins_issued"}, ins_issued, 0);
  endtask

  task automatic load_prog(input int n, input bit with_last);
    bit            pend;
    bit            exp_rdy;
    logic [AW-1:0] p_addr;
    logic [IW-1:0] p_data;
    logic [63:0]   rnd;
    pend = 1'b0; p_addr = '0; p_data = '0;
    for (int i = 0; i < n; i++) begin
      cyc();
      chk($sformatf("load w%0d ins_we", i), ins_we, pend);
      if (pend) begin
        chk($sformatf("load w%0d waddr", i), ins_waddr, p_addr);
        chk($sformatf("load w%0d wdata", i), ins_wdata, p_data);
      end
      rnd = {$urandom, $urandom};
      ld_valid = 1'b1;
      ld_data  = rnd[IW-1:0];
      ld_last  = with_last && (i == n - 1);
      #1;
      exp_rdy = m_closed || (m_len < DEPTH);
      chk($sformatf("load w%0d ld_ready", i), ld_ready, exp_rdy);
      pend = exp_rdy;
      if (exp_rdy) begin
        p_addr   = m_closed ? '0 : m_len[AW-1:0];
        p_data   = ld_data;
        m_len    = m_closed ? 1 : m_len + 1;
        m_closed = ld_last;
      end
    end
    cyc();
    chk("load tail ins_we", ins_we, pend);
    if (pend) begin
      chk("load tail waddr", ins_waddr, p_addr);
      chk("load tail wdata", ins_wdata, p_data);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    #1;
    chk("load prog_len", prog_len, m_len);
    cyc();
    chk("load idle ins_we", ins_we, 0);
  endtask

  // mode 0: no stalls, 1: stalls on absolute cycles 3-5, 2: random ~30% stalls.
  // done_at: retire number at which ins_done is raised (0 = never).
  task automatic do_run(input int len, input int mode, input int done_at,
                        input int exp_done, input int exp_runc, input string tag);
    bit st[256];
    bit rk[256];
    bit he[256];
    int adv, ret, run_len, dc, rc, rcount, k;
    bit in_run, in_drain;
    logic [63:0] rnd;
    for (int j = 0; j < 256; j++) begin
      case (mode)
        1:       st[j] = (j >= 1 && j <= 3);
        2:       st[j] = (j < 100) && ($urandom_range(0, 99) < 30);
        default: st[j] = 1'b0;
      endcase
      rk[j] = 1'b0; he[j] = 1'b0;
    end
    adv = 0; ret = 0; run_len = 0;
    for (int j = 0; j < 250 && run_len == 0; j++) begin
      he[j] = (adv % 2) == 1;
      if (!st[j]) begin
        if (adv % 2 == 1) begin
          ret++;
          rk[j] = 1'b1;
          if (ret == len || ret == done_at) run_len = j + 1;
        end
        adv++;
      end
    end
    dc = (exp_done >= 0) ? exp_done : 2 + run_len + DC;
    rc = (exp_runc >= 0) ? exp_runc : run_len + DC;
    rcount = 0;
    for (int c = 0; c <= dc + 1; c++) begin
      k = c - 2;
      in_run   = (c >= 2) && (k < run_len);
      in_drain = (c >= 2 + run_len) && (c < dc);
      cyc();
      rnd = {$urandom, $urandom};
      start    = (c == 0);
      ld_valid = (c == 0);
      ld_data  = rnd[IW-1:0];
      ld_last  = 1'b0;
      abort    = (c == dc);
      ext_stall = in_run ? st[k] : 1'($urandom_range(0, 1));
      if (in_run && rk[k]) begin
        rcount++;
        ins_done = (rcount == done_at);
      end else begin
        ins_done = 1'($urandom_range(0, 1));
      end
      #1;
      chk($sformatf("%s c%0d busy,done", tag, c), {busy, done}, {(c >= 1 && c <= dc), (c == dc)});
      if (c == 0) chk($sformatf("%s c0 ld_ready", tag), ld_ready, 0);
      if (c == 1) begin
        chk($sformatf("%s c1 ins_we", tag), ins_we, 0);
        chk($sformatf("%s c1 dec_rstn,half,stall", tag), {dec_rstn, half_clk, stall}, 3'b001);
      end
      if (in_run) begin
        chk($sformatf("%s c%0d half_clk", tag, c), half_clk, he[k]);
        chk($sformatf("%s c%0d stall,dec_rstn", tag, c), {stall, dec_rstn}, {st[k], 1'b1});
      end
      if (in_drain) chk($sformatf("%s c%0d drain half,stall", tag, c), {half_clk, stall}, 2'b01);
      if (c == dc + 1) begin
        chk($sformatf("%s run_cycles", tag), run_cycles, rc);
        chk($sformatf("%s ins_issued", tag), ins_issued, ret);
      end
    end
    idle_inputs();
  endtask

  task automatic zero_len_start(input string tag);
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    #1;
    chk({tag, " busy,done"}, {busy, done}, 2'b11);
    cyc();
    chk({tag, " after busy,done"}, {busy, done}, 2'b00);
    chk({tag, " run_cycles"}, run_cycles, 0);
    chk({tag, " ins_issued"}, ins_issued, 0);
  endtask

  initial begin
    int len;
    idle_inputs();
    rstn = 1'b0;
    repeat (3) cyc();
    chk_reset("reset");
    rstn = 1'b1;

    zero_len_start("zero_len");

    load_prog(3, 1'b1);
    do_run(3, 0, 0, 10, 8, "plan_nostall");
    do_run(3, 1, 0, 13, 11, "plan_stall3to5");

    load_prog(8, 1'b1);
    do_run(8, 0, 2, -1, -1, "ins_done_at2");

    // Abort mid-run on a non-retire cycle after one retire.
    cyc(); start = 1'b1;
    cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    abort = 1'b1;
    #1;
    chk("abort c4 half_clk", half_clk, 0);
    cyc();
    abort = 1'b0;
    #1;
    chk("abort busy,done", {busy, done}, 2'b00);
    chk("abort half,stall,dec_rstn", {half_clk, stall, dec_rstn}, 3'b010);
    chk("abort ins_issued", ins_issued, 1);
    chk("abort prog_len", prog_len, 8);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("abort idle%0d busy,done", i), {busy, done}, 2'b00);
    end
    do_run(8, 2, 0, -1, -1, "rerun_after_abort");

    for (int i = 0; i < 4; i++) begin
      len = $urandom_range(1, 6);
      load_prog(len, 1'b1);
      do_run(len, 2, $urandom_range(0, len), -1, -1, $sformatf("rand%0d", i));
    end

    load_prog(DEPTH + 1, 1'b0);

    // Reset in the middle of a run of the full program.
    cyc(); start = 1'b1;
    cyc(); start = 1'b0;
    repeat (5) cyc();
    chk("midrun busy", busy, 1);
    rstn = 1'b0;
    cyc();
    chk_reset("midrun_reset");
    rstn = 1'b1;
    m_len = 0; m_closed = 1'b0;
    zero_len_start("zero_len_after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/simd_sequencer.md
Name: simd_sequencer

Overview:
Run-control block for the SIMD core. It loads a program into instruction memory from a host write stream, then starts, paces and terminates execution. While running it drives the decoder's half_clk, stall and reset. It reports busy/done and cycle/instruction counts to the host.

Parameters:
INS_ADDR_WIDTH, 10, instruction memory address width; depth = 2^INS_ADDR_WIDTH
INS_WIDTH, 33, instruction word width (3-bit opcode + 3 x 10-bit addresses)
DRAIN_CYCLES, 2, clocks waited after the last issue for datapath write-back (>=1)
CNT_WIDTH, 32, width of the performance counters

Ports:
clk  in  1  single clock, rising edge
rstn  in  1  reset, synchronous, active-low
ld_valid  in  1  host program word valid
ld_ready  out  1  program word accepted when ld_valid & ld_ready
ld_data  in  INS_WIDTH  program word
ld_last  in  1  marks final word of program
ins_we  out  1  instruction memory write enable
ins_waddr  out  INS_ADDR_WIDTH  instruction memory write address
ins_wdata  out  INS_WIDTH  instruction memory write data
start  in  1  run request, sampled in IDLE only
abort  in  1  cancel run
ext_stall  in  1  datapath/memory back-pressure
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle pulse at normal completion
prog_len  out  INS_ADDR_WIDTH+1  words in loaded program
dec_rstn  out  1  decoder synchronous reset (active-low)
half_clk  out  1  decoder advance phase
stall  out  1  decoder stall
ins_done  in  1  decoder terminate flag (NOP opcode or pc at max)
run_cycles  out  CNT_WIDTH  clocks spent in RUN+DRAIN of the last/current run
ins_issued  out  CNT_WIDTH  instructions retired in the last/current run

Behaviour:
- Reset values: state=IDLE; ins_we=0; ins_waddr=0; ins_wdata=0; prog_len=0; dec_rstn=0; half_clk=0; stall=1; busy=0; done=0; run_cycles=0; ins_issued=0.
- States: IDLE, CLR, RUN, DRAIN, DONE.
- Load path (IDLE only):
  - ld_ready = (state==IDLE) & !start & (wcount < 2^INS_ADDR_WIDTH).
  - On accept, ins_we/ins_waddr/ins_wdata are registered: 1-cycle latency, ins_we high for exactly 1 cycle.
  - Address starts at 0 and increments per accepted word; prog_len = words accepted.
  - An accepted word with ld_last closes the program. The next accepted word starts a new program at address 0 and sets prog_len=1.
  - When memory is full, ld_ready=0; further words are not accepted.
- IDLE:
  - start=1 with prog_len>0 -> CLR.
  - start=1 with prog_len==0 -> DONE directly (no run, counters cleared).
  - start wins over a simultaneous ld_valid.
- CLR (1 cycle): dec_rstn=0, half_clk=0, stall=1; clears run_cycles and ins_issued -> RUN.
- RUN:
  - dec_rstn=1; stall=ext_stall.
  - half_clk starts at 0 on RUN entry and toggles each clock while ext_stall=0; it holds its value while ext_stall=1.
  - A retire occurs on any cycle with half_clk=1 & ext_stall=0; each retire increments ins_issued.
  - Retire with (ins_done=1 or ins_issued+1==prog_len) -> DRAIN.
  - run_cycles increments every clock in RUN and DRAIN.
- DRAIN:
  - half_clk=0, stall=1.
  - Counts DRAIN_CYCLES clocks regardless of ext_stall, then -> DONE.
- DONE (1 cycle): done=1, busy=1 -> IDLE.
- Counters hold their values in IDLE until the next start.
- abort=1 in CLR/RUN/DRAIN -> IDLE next cycle:
  - no done pulse; half_clk=0, stall=1;
  - counters frozen; prog_len and memory contents retained.
- abort is ignored in IDLE and DONE.
- rstn low mid-run -> IDLE with reset values; memory contents are not cleared, but prog_len=0.
- Counters saturate at all-ones; they do not wrap.

Test Plan:
- Load 3 words (ld_last on 3rd), no back-pressure -> ins_we pulses with waddr 0,1,2 one cycle after each accept; prog_len=3.
- prog_len=3, start at cycle 0, ext_stall=0, ins_done=0:
  - CLR at cycle 1 (dec_rstn=0);
  - half_clk 0,1,0,1,0,1 in cycles 2-7;
  - DRAIN in cycles 8-9; done=1 at cycle 10; busy=1 in cycles 1-10;
  - ins_issued=3, run_cycles=8.
- Same as above with ext_stall=1 during cycles 3-5 -> half_clk held at 1 through cycles 3-5, no retire there; done at cycle 13; run_cycles=11.
- prog_len=8, ins_done=1 at 2nd retire -> DRAIN after ins_issued=2; done pulses once; ins_issued=2.
- abort in RUN -> IDLE next cycle, done never pulses, busy=0; a following start reruns from CLR with counters cleared.
- Edge cases:
  - start with prog_len==0 -> done the next cycle, run_cycles=0;
  - loading 1025 words at depth 1024 -> ld_ready=0 after 1024 accepts;
  - start and ld_valid in the same cycle -> no write, run starts.
